// File: rtl/vthernet_pkg.sv
// Shared definitions for the RX payload DMA master: master FSM states,
// byte-lane helpers and the layout of one word-FIFO entry.
package vthernet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } wbm_state_t;

    localparam logic [3:0] WB_SEL_FULL = 4'hF;

    // One buffered bus word: frame-end marker, byte enables, little-endian data.
    typedef struct packed {
        logic        last;
        logic [3:0]  sel;
        logic [31:0] data;
    } fifo_entry_t;

    localparam int FIFO_ENTRY_W = $bits(fifo_entry_t);

    // Byte enables for a word holding nbytes bytes starting at lane 0.
    function automatic logic [3:0] nbytes_to_sel(input logic [2:0] nbytes);
        case (nbytes)
            3'd0:    nbytes_to_sel = 4'h0;
            3'd1:    nbytes_to_sel = 4'h1;
            3'd2:    nbytes_to_sel = 4'h3;
            3'd3:    nbytes_to_sel = 4'h7;
            default: nbytes_to_sel = WB_SEL_FULL;
        endcase
    endfunction

endpackage

// File: rtl/wb_word_fifo.sv
// Small synchronous FIFO with first-word-fall-through head output.
// A push while full is accepted only when a pop happens in the same cycle.
module wb_word_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/wb_rx_dma_master.sv
// Packs the received payload byte stream into little-endian 32-bit words
// and writes each frame to memory from BASE_ADDR with single Wishbone
// classic write cycles, reporting frame completion and error status.
module wb_rx_dma_master
    import vthernet_pkg::*;
#(
    parameter int          OCT              = 8,
    parameter int          FIFO_DEPTH       = 4,
    parameter logic [31:0] BASE_ADDR        = 32'h4000_0000,
    parameter int          ADDR_WINDOW_BITS = 12,
    parameter int          TIMEOUT_CYCLES   = 255
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    input  logic           in_data_v,
    input  logic [OCT-1:0] in_data,
    input  logic           in_last,
    output logic           wbm_cyc_o,
    output logic           wbm_stb_o,
    output logic           wbm_we_o,
    output logic [3:0]     wbm_sel_o,
    output logic [31:0]    wbm_adr_o,
    output logic [31:0]    wbm_dat_o,
    input  logic           wbm_ack_i,
    output logic           frame_done,
    output logic [15:0]    frame_len,
    output logic           overflow,
    output logic           bus_err,
    output logic           busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    wbm_state_t  r_state, w_state_next;
    logic [1:0]  r_lane;
    logic [31:0] r_pack_data;
    logic [31:0] w_word_data;
    logic [15:0] r_byte_cnt;
    logic [15:0] r_frame_len;
    logic        r_in_frame;
    logic        r_overflow, r_bus_err;
    logic        r_cyc;
    logic [3:0]  r_sel;
    logic [31:0] r_adr, r_dat;
    logic [TW-1:0]               r_tmo;
    logic [ADDR_WINDOW_BITS-1:0] r_offset;
    logic        r_frame_done, r_last_pending;
    logic        w_push_req, w_drop, w_pop, w_ack_seen, w_timeout, w_frame_start;
    logic        w_fifo_full, w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    fifo_entry_t w_entry_in, w_head;

    // Incoming byte lands in the lane currently being filled; other lanes keep packer contents.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_word_data[gi*OCT +: OCT] = (r_lane == 2'(gi)) ? in_data : r_pack_data[gi*OCT +: OCT];
    end

    assign w_push_req    = in_data_v && ((r_lane == 2'd3) || in_last);
    assign w_drop        = w_push_req && w_fifo_full && !w_pop;
    assign w_frame_start = in_data_v && !r_in_frame;

    // Assemble the FIFO entry for the word completed this cycle.
    always_comb begin
        w_entry_in.last = in_last;
        w_entry_in.sel  = nbytes_to_sel({1'b0, r_lane} + 3'd1);
        w_entry_in.data = w_word_data;
    end

    wb_word_fifo #(
        .WIDTH (FIFO_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (wb_clk_i),
        .srst    (wb_rst_i),
        .i_push  (w_push_req),
        .i_pop   (w_pop),
        .i_din   (w_entry_in),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Byte packer, per-frame byte counter and frame-length capture.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_lane      <= '0;
            r_pack_data <= '0;
            r_byte_cnt  <= '0;
            r_frame_len <= '0;
            r_in_frame  <= 1'b0;
        end else if (in_data_v) begin
            if (w_push_req) begin
                r_lane      <= '0;
                r_pack_data <= '0;
            end else begin
                r_lane      <= r_lane + 2'd1;
                r_pack_data <= w_word_data;
            end
            if (in_last) begin
                r_frame_len <= r_byte_cnt + 16'd1;
                r_byte_cnt  <= '0;
                r_in_frame  <= 1'b0;
            end else begin
                r_byte_cnt  <= r_byte_cnt + 16'd1;
                r_in_frame  <= 1'b1;
            end
        end
    end

    // Sticky error flags; a new error wins over the clear at a frame's first byte.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_overflow <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            if (w_drop)             r_overflow <= 1'b1;
            else if (w_frame_start) r_overflow <= 1'b0;
            if (w_timeout)          r_bus_err  <= 1'b1;
            else if (w_frame_start) r_bus_err  <= 1'b0;
        end
    end

    // Master state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state logic: a cycle ends on ack or timeout, then one idle GAP cycle.
    always_comb begin
        w_state_next = r_state;
        w_ack_seen   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: if (!w_fifo_empty) w_state_next = ST_REQ;
            ST_REQ: begin
                if (wbm_ack_i) begin
                    w_ack_seen   = 1'b1;
                    w_state_next = ST_GAP;
                end else if (r_tmo == TMO_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_pop = w_ack_seen || w_timeout;

    // Bus outputs, timeout counter, frame offset and frame-done generation.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cyc          <= 1'b0;
            r_sel          <= '0;
            r_adr          <= '0;
            r_dat          <= '0;
            r_tmo          <= '0;
            r_offset       <= '0;
            r_frame_done   <= 1'b0;
            r_last_pending <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_state == ST_IDLE && !w_fifo_empty) begin
                r_cyc <= 1'b1;
                r_sel <= w_head.sel;
                r_dat <= w_head.data;
                r_adr <= BASE_ADDR + 32'(r_offset);
                r_tmo <= '0;
            end else if (r_state == ST_REQ) begin
                r_tmo <= r_tmo + TW'(1);
            end
            // Acked and timed-out words retire the same way: the address advances
            // and a frame-end word rewinds the offset and reports completion.
            if (w_pop) begin
                r_cyc <= 1'b0;
                if (w_head.last) begin
                    r_offset     <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_offset     <= r_offset + ADDR_WINDOW_BITS'(4);
                end
            end
            // A dropped frame-end word is reported once everything ahead of it has drained.
            if (w_drop && in_last) begin
                r_last_pending <= 1'b1;
            end else if (r_last_pending && w_fifo_empty && r_state != ST_REQ) begin
                r_last_pending <= 1'b0;
                r_frame_done   <= 1'b1;
            end
        end
    end

    assign wbm_cyc_o  = r_cyc;
    assign wbm_stb_o  = r_cyc;
    assign wbm_we_o   = r_cyc;
    assign wbm_sel_o  = r_sel;
    assign wbm_adr_o  = r_adr;
    assign wbm_dat_o  = r_dat;
    assign frame_done = r_frame_done;
    assign frame_len  = r_frame_len;
    assign overflow   = r_overflow;
    assign bus_err    = r_bus_err;
    assign busy       = (w_fifo_count != '0) || r_cyc;

endmodule

// File: tb/tb_wb_rx_dma_master.sv
// Scoreboard bench for wb_rx_dma_master: expected bus writes and frame
// reports are queued from a frame-level model before stimulus is driven;
// independent monitor processes compare whatever the DUT presents.
module tb_wb_rx_dma_master;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          TMO  = 255;

    logic        wb_clk_i, wb_rst_i;
    logic        in_data_v, in_last;
    logic [7:0]  in_data;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        frame_done, overflow, bus_err, busy;
    logic [15:0] frame_len;

    wb_rx_dma_master dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .in_data_v  (in_data_v),
        .in_data    (in_data),
        .in_last    (in_last),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_ack_i  (wbm_ack_i),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .overflow   (overflow),
        .bus_err    (bus_err),
        .busy       (busy)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wr_t;

    typedef struct {
        logic [15:0] len;
        logic        ovf;
        logic        berr;
    } fd_t;

    wr_t        exp_wr_q[$];
    fd_t        exp_fd_q[$];
    logic [7:0] fbytes[$];
    int         m_off = 0;
    int         n_vec = 0;
    int         n_err = 0;
    bit         no_ack = 1'b0;
    int         ack_min = 0;
    int         ack_max = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Frame-level reference: split into 4-byte little-endian words, address
    // from the running offset. Words beyond 'keep' are lost to overflow and
    // never reach the bus, so they neither advance nor rewind the offset.
    task automatic model_frame(input int keep, input bit ovf, input bit berr);
        int n, nw, cnt;
        logic [31:0] d;
        wr_t w;
        fd_t f;
        n  = fbytes.size();
        nw = (n + 3) / 4;
        for (int wi = 0; wi < nw; wi++) begin
            cnt = ((n - 4 * wi) >= 4) ? 4 : (n - 4 * wi);
            d = 32'h0;
            for (int k = 0; k < cnt; k++) d = d | (32'(fbytes[4 * wi + k]) << (8 * k));
            if (wi < keep) begin
                w.adr = BASE + 32'(m_off);
                w.dat = d;
                w.sel = 4'((1 << cnt) - 1);
                exp_wr_q.push_back(w);
                m_off = (wi == nw - 1) ? 0 : ((m_off + 4) % 4096);
            end
        end
        f.len  = 16'(n % 65536);
        f.ovf  = ovf;
        f.berr = berr;
        exp_fd_q.push_back(f);
    endtask

    // Drive the frame in fbytes; 'gap' idle cycles follow each byte, with
    // stray in_last pulses that carry no valid byte.
    task automatic drive_frame(input int gap);
        for (int i = 0; i < fbytes.size(); i++) begin
            @(negedge wb_clk_i);
            in_data_v = 1'b1;
            in_data   = fbytes[i];
            in_last   = (i == fbytes.size() - 1);
            for (int g = 0; g < gap; g++) begin
                @(negedge wb_clk_i);
                in_data_v = 1'b0;
                in_last   = 1'($urandom_range(1, 0));
            end
        end
        @(negedge wb_clk_i);
        in_data_v = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'h00;
    endtask

    task automatic wait_idle(input int bound);
        int t;
        t = 0;
        while ((exp_fd_q.size() != 0 || busy !== 1'b0) && t < bound) begin
            @(negedge wb_clk_i);
            t++;
        end
        if (t >= bound) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_wait: still busy after %0d cycles, %0d frame reports outstanding, required 0",
                     bound, exp_fd_q.size());
            exp_fd_q.delete();
            exp_wr_q.delete();
        end
        @(negedge wb_clk_i);
    endtask

    task automatic fill_seq(input int n, input int first);
        fbytes.delete();
        for (int i = 0; i < n; i++) fbytes.push_back(8'(first + i));
    endtask

    task automatic fill_rand(input int n);
        fbytes.delete();
        for (int i = 0; i < n; i++) fbytes.push_back(8'($urandom));
    endtask

    // Wishbone target: acks each strobe after a delay drawn from [ack_min, ack_max].
    initial begin : responder
        int cnt, dly;
        wbm_ack_i = 1'b0;
        cnt = 0;
        dly = 0;
        forever begin
            @(negedge wb_clk_i);
            wbm_ack_i = 1'b0;
            if (wbm_cyc_o === 1'b1 && wbm_stb_o === 1'b1 && !no_ack) begin
                if (cnt == 0) dly = int'($urandom_range(ack_max, ack_min));
                if (cnt >= dly) begin
                    wbm_ack_i = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: compares each new bus cycle and each frame report against the queues.
    initial begin : monitor
        logic prev_cyc;
        int   stb_cnt;
        wr_t  e;
        fd_t  f;
        prev_cyc = 1'b0;
        stb_cnt  = 0;
        forever begin
            @(negedge wb_clk_i);
            if (wbm_cyc_o === 1'b1 && !prev_cyc) begin
                stb_cnt = 0;
                if (exp_wr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wr_unexpected: got write adr 0x%08h dat 0x%08h, required no write",
                             wbm_adr_o, wbm_dat_o);
                end else begin
                    e = exp_wr_q.pop_front();
                    chk("wr_adr", wbm_adr_o, e.adr);
                    chk("wr_dat", wbm_dat_o, e.dat);
                    chk("wr_sel", 32'(wbm_sel_o), 32'(e.sel));
                    chk("wr_we_stb", {30'h0, wbm_we_o, wbm_stb_o}, 32'h3);
                    $display("wr   adr=0x%08h dat=0x%08h sel=0x%h", wbm_adr_o, wbm_dat_o, wbm_sel_o);
                end
            end
            if (wbm_stb_o === 1'b1) stb_cnt++;
            if (prev_cyc && wbm_cyc_o !== 1'b1 && no_ack) chk("stb_len", 32'(stb_cnt), 32'(TMO));
            prev_cyc = (wbm_cyc_o === 1'b1);
            if (frame_done === 1'b1) begin
                if (exp_fd_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL fd_unexpected: got frame_done len %0d, required no frame_done", frame_len);
                end else begin
                    f = exp_fd_q.pop_front();
                    chk("frame_len", 32'(frame_len), 32'(f.len));
                    chk("overflow", 32'(overflow), 32'(f.ovf));
                    chk("bus_err", 32'(bus_err), 32'(f.berr));
                    $display("done len=%0d overflow=%0d bus_err=%0d", frame_len, overflow, bus_err);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t;
        wb_rst_i  = 1'b1;
        in_data_v = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;

        // Reset state after the first sampled reset edge.
        @(negedge wb_clk_i);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'h0);
        chk("rst_stb", 32'(wbm_stb_o), 32'h0);
        chk("rst_we", 32'(wbm_we_o), 32'h0);
        chk("rst_sel", 32'(wbm_sel_o), 32'h0);
        chk("rst_adr", wbm_adr_o, 32'h0);
        chk("rst_dat", wbm_dat_o, 32'h0);
        chk("rst_done", 32'(frame_done), 32'h0);
        chk("rst_len", 32'(frame_len), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_berr", 32'(bus_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // Two full words, immediate ack.
        fill_seq(8, 8'h01);
        model_frame(1 << 30, 1'b0, 1'b0);
        drive_frame(0);
        wait_idle(500);

        // Partial final word; the following frames must restart at BASE.
        fill_seq(5, 8'hA1);
        model_frame(1 << 30, 1'b0, 1'b0);
        drive_frame(0);
        wait_idle(500);

        // Random frames, random byte spacing and ack latency.
        ack_max = 3;
        repeat (20) begin
            fill_rand(int'($urandom_range(20, 1)));
            model_frame(1 << 30, 1'b0, 1'b0);
            drive_frame(int'($urandom_range(3, 1)));
            wait_idle(1000);
        end
        ack_max = 0;

        // Target never acks: both words time out, frame still completes.
        no_ack = 1'b1;
        fill_rand(8);
        model_frame(1 << 30, 1'b0, 1'b1);
        drive_frame(0);
        wait_idle(1500);
        no_ack = 1'b0;
        chk("bus_err_sticky", 32'(bus_err), 32'h1);

        // Next frame clears bus_err on its first byte.
        fill_rand(4);
        model_frame(1 << 30, 1'b0, 1'b0);
        drive_frame(0);
        wait_idle(500);

        // Stalled target: only the FIFO's worth of words survives the burst.
        ack_min = 40;
        ack_max = 40;
        fill_seq(24, 8'h10);
        model_frame(4, 1'b1, 1'b0);
        drive_frame(0);
        wait_idle(1000);
        chk("overflow_sticky", 32'(overflow), 32'h1);
        ack_min = 0;
        ack_max = 0;

        // Lost frame-end word left the offset advanced.
        fill_rand(4);
        model_frame(1 << 30, 1'b0, 1'b0);
        drive_frame(0);
        wait_idle(500);

        // Long frame wraps the 4 KiB window.
        fill_rand(4104);
        model_frame(1 << 30, 1'b0, 1'b0);
        drive_frame(0);
        wait_idle(500);

        // Reset during an active strobe.
        ack_min = 30;
        ack_max = 30;
        fill_rand(4);
        model_frame(1 << 30, 1'b0, 1'b0);
        drive_frame(0);
        t = 0;
        while (wbm_stb_o !== 1'b1 && t < 50) begin
            @(negedge wb_clk_i);
            t++;
        end
        if (t >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL stb_wait: no strobe within 50 cycles, required strobe");
        end
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        chk("mid_rst_cyc", 32'(wbm_cyc_o), 32'h0);
        chk("mid_rst_stb", 32'(wbm_stb_o), 32'h0);
        chk("mid_rst_len", 32'(frame_len), 32'h0);
        chk("mid_rst_flags", {28'h0, frame_done, overflow, bus_err, busy}, 32'h0);
        chk("mid_rst_adr", wbm_adr_o, 32'h0);
        chk("mid_rst_dat", wbm_dat_o, 32'h0);
        exp_wr_q.delete();
        exp_fd_q.delete();
        m_off = 0;
        ack_min = 0;
        ack_max = 0;
        @(negedge wb_clk_i);

        // After reset the next frame starts at BASE.
        fill_seq(4, 8'hC0);
        model_frame(1 << 30, 1'b0, 1'b0);
        drive_frame(0);
        wait_idle(500);

        chk("wr_q_left", 32'(exp_wr_q.size()), 32'h0);
        chk("fd_q_left", 32'(exp_fd_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
